// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the fetch queue.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000000;
   localparam logic [31:0] RESET_PC  = 32'h00003000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode bus of the instruction fetch queue.
interface instr_fetch_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic [DATA_W-1:0] in_pc;
   logic [DATA_W-1:0] in_instr;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_pc8;
   logic [DATA_W-1:0] out_instr;
   logic              flush;
   logic [CNT_W-1:0]  count;

   // Pipeline side: fetch pushes, decode pops, redirect flushes.
   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_pc8, out_instr, count
   );

   // Queue side.
   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_pc8, out_instr, count
   );
endinterface

// File: rtl/fq_ptr_ctrl.sv
// Pointer/occupancy control for the fetch queue: push/pop/flush priority.
module fq_ptr_ctrl #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic             in_ready,
   output logic             out_valid,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0] count_d, count_q;
   logic             push, pop;

   // Handshakes depend on state only; next-state applies reset > flush > push/pop.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      in_ready  = (count_q < CNT_W'(DEPTH));
      out_valid = (count_q != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      wr_en     = push & ~flush & ~reset;
      if (reset || flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   // State register; synchronous reset is folded into the next-state logic.
   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign count  = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {PC, instruction} between IF and ID, with single-cycle flush.
module instr_fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_queue_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fq_entry_t        storage_d [DEPTH];
   fq_entry_t        storage_q [DEPTH];
   fq_entry_t        head;
   logic             wr_en;
   logic             out_valid;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   fq_ptr_ctrl #(
      .DEPTH(DEPTH)
   ) u_ptr_ctrl (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (bus.in_valid),
      .out_ready (bus.out_ready),
      .flush     (bus.flush),
      .in_ready  (bus.in_ready),
      .out_valid (out_valid),
      .wr_en     (wr_en),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .count     (bus.count)
   );

   // Storage changes only on an accepted, non-flushed push; pops leave it untouched.
   always_comb begin
      storage_d = storage_q;
      if (wr_en) begin
         storage_d[wr_ptr] = '{pc: bus.in_pc, instr: bus.in_instr};
      end
   end

   // Storage register, deliberately not reset.
   always_ff @(posedge clk) begin
      storage_q <= storage_d;
   end

   // Head read mux; an empty queue shows a nop at PC 0.
   always_comb begin
      head = '{pc: '0, instr: NOP_INSTR};
      if (out_valid) head = storage_q[rd_ptr];
   end

   assign bus.out_valid = out_valid;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
   assign bus.out_pc8   = head.pc + DATA_W'(8);

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Decoupling buffer between the instruction fetch stage and the ID stage of the 5-stage MIPS pipeline. Captures each fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. Lets fetch run ahead while decode is stalled by hazards. A single-cycle flush discards all wrong-path instructions on a branch or jump redirect.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
DATA_W, 32, instruction and PC width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears the queue
in_valid  in  1  fetch presents a valid {in_pc, in_instr} this cycle
in_pc  in  32  PC of fetched instruction
in_instr  in  32  fetched instruction word
in_ready  out  1  queue can accept a push this cycle
out_valid  out  1  head entry is valid for decode
out_ready  in  1  decode consumes head this cycle
out_pc  out  32  PC of head entry
out_pc8  out  32  out_pc + 8, the link address for jal/jalr
out_instr  out  32  head instruction; 32'h00000000 (nop) when empty
flush  in  1  redirect; discard all entries, including any push this cycle
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH). This is combinational from state only, with no dependence on out_ready: there is no same-cycle push-through when full.
- out_valid = (count != 0). out_pc and out_instr are read combinationally from storage[rd_ptr].
- When empty: out_instr = 0, out_pc = 0, out_pc8 = 8.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass from input to output.
- Pointers wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap modulo DEPTH. count tracks occupancy separately.
- Count update rules:
  - push only: count+1
  - pop only: count-1
  - push and pop together: unchanged; write at wr_ptr, read advances
- Full: in_ready = 0, and in_valid is ignored (fetch holds its PC).
- Empty: out_ready is ignored, and no pointer moves.
- Priority: reset > flush > push/pop.
  - flush = 1: next cycle count = 0 and wr_ptr = rd_ptr = 0. A same-cycle push and pop have no effect.
  - in_ready is still computed from the pre-flush count.
- Reset behaviour:
  - Identical to flush. Storage contents need not be cleared.
  - All outputs reach their empty values one cycle after reset is sampled.
  - Reset mid-stream loses all entries.
- out_pc8 is a 32-bit add with wrap-around; no overflow flag.
- Storage is written only on push. A pop never modifies storage.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h00000000
  - RESET_PC = 32'h00003000
  - typedef fq_entry_t {pc[31:0], instr[31:0]}
- One natural sub-module: fq_ptr_ctrl. It holds the wr_ptr/rd_ptr/count state and the push/pop/flush priority logic, and outputs in_ready, out_valid and the pointers.
- Top level holds the fq_entry_t storage array and the read mux.

Test Plan:
1. Reset, then push 0x3000/0x24010001 with out_ready = 0 -> next cycle out_valid = 1, out_pc = 0x3000, out_pc8 = 0x3008, count = 1.
2. Push 4 entries (PCs 0x3000..0x300C) with out_ready = 0 -> count = 4, in_ready = 0. A 5th in_valid is ignored. Then pop 4 -> PCs returned in order, count = 0, out_instr = 0.
3. Continuous push and pop every cycle for 10 cycles from PC 0x3000 -> count stays at 1 after the first cycle. out_pc sequence is 0x3000, 0x3004, … with pointer wrap-around and no loss or duplication.
4. Fill 3 entries, then assert flush together with in_valid (PC 0x4000) and out_ready -> next cycle count = 0, out_valid = 0, and 0x4000 is not stored.
5. Full queue with push and pop in the same cycle -> the pop succeeds, the push is refused (in_ready was 0), count = 3.
6. Reset asserted mid-stream with count = 2 -> next cycle count = 0, out_valid = 0, in_ready = 1. A subsequent push of 0x3000 appears at the head one cycle later.
